// File: rtl/mc_ctrl_pkg.sv
// Shared types and field codes for the multicycle control FSM.
// Optional memory wait-state support is enabled with MC_CTRL_MEMWAIT_EN.
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_ALUWB    = 4'd7,
      S_EXECI    = 4'd8,
      S_JAL      = 4'd9,
      S_BEQ      = 4'd10
   } state_t;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_BEQ = 7'b1100011;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_DATA   = 2'b01;
   localparam logic [1:0] RES_ALURES = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   typedef struct packed {
      logic       pc_update;
      logic       branch;
      logic       adr_src;
      logic       mem_write;
      logic       ir_write;
      logic       reg_write;
      logic [1:0] result_src;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
   } ctrl_t;

   function automatic logic op_known(input logic [6:0] op);
      logic known;
      case (op)
         OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ: known = 1'b1;
         default:                                 known = 1'b0;
      endcase
      return known;
   endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Pure state-to-control decode for the multicycle controller (Moore outputs).
module mc_ctrl_outdec
   import mc_ctrl_pkg::*;
(
   input  logic [3:0] state,
   output ctrl_t      ctrl
);

   // Per-state control vector; anything not set stays zero.
   always_comb begin
      ctrl = '0;
      case (state)
         S_FETCH: begin
            ctrl.ir_write   = 1'b1;
            ctrl.alu_src_b  = SRCB_FOUR;
            ctrl.result_src = RES_ALURES;
            ctrl.pc_update  = 1'b1;
         end
         S_DECODE: begin
            ctrl.alu_src_a = SRCA_OLDPC;
            ctrl.alu_src_b = SRCB_IMM;
         end
         S_MEMADR: begin
            ctrl.alu_src_a = SRCA_RS1;
            ctrl.alu_src_b = SRCB_IMM;
         end
         S_MEMREAD: ctrl.adr_src = 1'b1;
         S_MEMWB: begin
            ctrl.result_src = RES_DATA;
            ctrl.reg_write  = 1'b1;
         end
         S_MEMWRITE: begin
            ctrl.adr_src   = 1'b1;
            ctrl.mem_write = 1'b1;
         end
         S_EXECR: begin
            ctrl.alu_src_a = SRCA_RS1;
            ctrl.alu_op    = ALUOP_FUNCT;
         end
         S_EXECI: begin
            ctrl.alu_src_a = SRCA_RS1;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_op    = ALUOP_FUNCT;
         end
         S_ALUWB: ctrl.reg_write = 1'b1;
         S_JAL: begin
            ctrl.alu_src_a = SRCA_OLDPC;
            ctrl.alu_src_b = SRCB_FOUR;
            ctrl.pc_update = 1'b1;
         end
         S_BEQ: begin
            ctrl.alu_src_a = SRCA_RS1;
            ctrl.alu_op    = ALUOP_SUB;
            ctrl.branch    = 1'b1;
         end
         default: ctrl = '0;
      endcase
   end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle RISC-V style control FSM: state register, next-state logic, PCWrite and pulses.
// Define MC_CTRL_MEMWAIT_EN to stall FETCH/MEMREAD/MEMWRITE until MemReady.
module mc_ctrl
   import mc_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic       Zero,
   input  logic       MemReady,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic       InstrDone,
   output logic       IllegalInstr,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic [3:0] State
);

   state_t state;
   state_t next_state;
   ctrl_t  ctrl;
   logic   mem_go;
   logic   instr_done;
   logic   illegal;
   logic   pc_gate;

`ifdef MC_CTRL_MEMWAIT_EN
   assign mem_go = MemReady;
`else
   logic unused_mem_ready;
   assign unused_mem_ready = MemReady;
   assign mem_go           = 1'b1;
`endif

   mc_ctrl_outdec u_outdec (
      .state (state),
      .ctrl  (ctrl)
   );

   // Next-state selection; op is only looked at in DECODE and MEMADR.
   always_comb begin
      next_state = S_FETCH;
      case (state)
         S_FETCH:    next_state = mem_go ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: next_state = S_MEMADR;
               OP_R:         next_state = S_EXECR;
               OP_I:         next_state = S_EXECI;
               OP_JAL:       next_state = S_JAL;
               OP_BEQ:       next_state = S_BEQ;
               default:      next_state = S_FETCH;
            endcase
         end
         S_MEMADR:   next_state = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD:  next_state = mem_go ? S_MEMWB : S_MEMREAD;
         S_MEMWRITE: next_state = mem_go ? S_FETCH : S_MEMWRITE;
         S_EXECR, S_EXECI, S_JAL: next_state = S_ALUWB;
         S_MEMWB, S_ALUWB, S_BEQ: next_state = S_FETCH;
         default:    next_state = S_FETCH;
      endcase
   end

   // State register with synchronous reset back to FETCH.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_FETCH;
      end else begin
         state <= next_state;
      end
   end

   // Completion pulse: any legal exit to FETCH.
   always_comb begin
      instr_done = 1'b0;
      case (state)
         S_MEMWB, S_ALUWB, S_BEQ: instr_done = 1'b1;
         S_MEMWRITE:              instr_done = mem_go;
         default:                 instr_done = 1'b0;
      endcase
   end

   assign illegal = (state == S_DECODE) && !op_known(op);
   // A stalled FETCH must neither load IR nor advance PC.
   assign pc_gate = (state != S_FETCH) || mem_go;

   // Drive outputs; everything is forced low while reset is held.
   always_comb begin
      PCWrite      = 1'b0;
      AdrSrc       = 1'b0;
      MemWrite     = 1'b0;
      IRWrite      = 1'b0;
      RegWrite     = 1'b0;
      InstrDone    = 1'b0;
      IllegalInstr = 1'b0;
      ResultSrc    = 2'b00;
      ALUSrcA      = 2'b00;
      ALUSrcB      = 2'b00;
      ALUOp        = 2'b00;
      State        = 4'd0;
      if (!reset) begin
         PCWrite      = (ctrl.pc_update & pc_gate) | (ctrl.branch & Zero);
         AdrSrc       = ctrl.adr_src;
         MemWrite     = ctrl.mem_write;
         IRWrite      = ctrl.ir_write & mem_go;
         RegWrite     = ctrl.reg_write;
         InstrDone    = instr_done;
         IllegalInstr = illegal;
         ResultSrc    = ctrl.result_src;
         ALUSrcA      = ctrl.alu_src_a;
         ALUSrcB      = ctrl.alu_src_b;
         ALUOp        = ctrl.alu_op;
         State        = state;
      end else begin
         State = 4'd0;
      end
   end

endmodule
